// File: rtl/trace_pkg.sv
// trace_pkg: shared record, state and default types for the retire trace buffer
package trace_pkg;
  localparam int SEQ_W = 16;
  localparam logic [31:0] PC_SENTINEL_DEF = 32'hFFFF_FFFF;
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      inst;
  } trace_rec_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, FROZEN} state_t;
endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: DEPTH x trace record storage, synchronous write, asynchronous read
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  trace_rec_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output trace_rec_t               rdata
);
  trace_rec_t mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: records one {seq, pc, inst} per retired instruction into a
// circular buffer drained through a first-word-fall-through valid/ready port.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] PC_SENTINEL = PC_SENTINEL_DEF,
  localparam int         PW          = $clog2(DEPTH),
  localparam int         CW          = PW + 1
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  input  logic             enable,
  input  logic             mode_wrap,
  input  logic [31:0]      pc_lo,
  input  logic [31:0]      pc_hi,
  input  logic             clear,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [SEQ_W-1:0] rd_seq,
  output logic [31:0]      rd_pc,
  output logic [31:0]      rd_inst,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             frozen,
  output logic [15:0]      ovf_cnt
);
  state_t           state, state_nx;
  logic [31:0]      pc_prev;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [SEQ_W-1:0] seq;
  trace_rec_t       head, wrec;
  logic             in_win, hit, pop, cap, freeze, push, over, drop;

  assign in_win = (pc_lo > pc_hi) || (pc >= pc_lo && pc <= pc_hi);
  assign hit    = (pc != pc_prev) & enable & in_win;
  assign pop    = rd_valid & rd_ready;
  // A hit seen while still IDLE is the first retire after enable and is kept.
  assign cap    = hit & (state != FROZEN);
  assign freeze = cap & full & !mode_wrap & !pop;
  assign push   = cap & !freeze & !clear;
  assign over   = push & full & !pop;
  assign drop   = hit & !clear & ((state == FROZEN) | freeze);
  assign wrec   = '{seq: seq, pc: pc, inst: inst};

  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb
    state_nx = clear ? IDLE :
               (state == FROZEN) ? (pop ? CAPTURE : FROZEN) :
               freeze ? FROZEN :
               enable ? CAPTURE : IDLE;

  always_comb begin
    frozen   = state == FROZEN;
    full     = count == CW'(DEPTH);
    rd_valid = count != '0;
    rd_seq   = rd_valid ? head.seq  : '0;
    rd_pc    = rd_valid ? head.pc   : '0;
    rd_inst  = rd_valid ? head.inst : '0;
  end

  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      pc_prev <= PC_SENTINEL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      seq     <= '0;
      ovf_cnt <= '0;
    end else begin
      pc_prev <= pc;
      if (clear) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        seq     <= '0;
        ovf_cnt <= '0;
      end else begin
        if (hit) seq <= seq + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop | over) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push & !over) - CW'(pop);
        if ((drop | over) && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
      end
    end

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk_in),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wrec),
    .raddr (rd_ptr),
    .rdata (head)
  );
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed scenario tests for retire_trace_buffer
module tb_retire_trace_buffer;
  logic        clk_in = 0, reset_n = 1;
  logic [31:0] pc = 0, inst = 0, pc_lo = 1, pc_hi = 0;
  logic        enable = 0, mode_wrap = 0, clear = 0, rd_ready = 0;
  logic        rd_valid, full, frozen;
  logic [15:0] rd_seq, ovf_cnt;
  logic [31:0] rd_pc, rd_inst;
  logic [4:0]  count;
  int tests = 0, fails = 0;

  retire_trace_buffer dut (
    .clk_in(clk_in), .reset_n(reset_n), .pc(pc), .inst(inst), .enable(enable),
    .mode_wrap(mode_wrap), .pc_lo(pc_lo), .pc_hi(pc_hi), .clear(clear),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_seq(rd_seq), .rd_pc(rd_pc),
    .rd_inst(rd_inst), .count(count), .full(full), .frozen(frozen), .ovf_cnt(ovf_cnt)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return p ^ 32'hDEAD_0000;
  endfunction

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk_in);
    reset_n = 0; enable = en; mode_wrap = 0; clear = 0; rd_ready = 0;
    pc_lo = 32'h1; pc_hi = 32'h0;
    step(); step();
    reset_n = 1;
  endtask

  task automatic hold(input logic [31:0] p, input int n);
    pc = p; inst = inst_of(p);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic feed(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) hold(base + 32'(4 * i), 1);
  endtask

  task automatic pop_one();
    rd_ready = 1; step(); rd_ready = 0;
  endtask

  task automatic test_reset();
    pc = 32'h0040_0000; inst = inst_of(pc);
    do_reset(1);
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", rd_valid); end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if ({full, frozen} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {full, frozen}); end
    tests++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
    tests++; if ({rd_seq, rd_pc, rd_inst} !== 80'd0) begin fails++; $display("FAIL reset_rd got %h want 0", {rd_seq, rd_pc, rd_inst}); end
  endtask

  task automatic test_basic_capture();
    hold(32'h0040_0000, 3); hold(32'h0040_0004, 3); hold(32'h0040_0008, 3);
    tests++; if (count !== 5'd3) begin fails++; $display("FAIL basic_count got %0d want 3", count); end
    hold(32'h0040_0008, 3);
    tests++; if (count !== 5'd3) begin fails++; $display("FAIL basic_hold_count got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rd_valid !== 1'b1 || rd_seq !== 16'(i) || rd_pc !== 32'h0040_0000 + 32'(4 * i) || rd_inst !== inst_of(32'h0040_0000 + 32'(4 * i))) begin
        fails++; $display("FAIL basic_entry%0d got v=%0b seq=%0d pc=%h inst=%h want seq=%0d", i, rd_valid, rd_seq, rd_pc, rd_inst, i);
      end
      pop_one();
    end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL basic_empty got %0b want 0", rd_valid); end
  endtask

  task automatic test_freeze();
    do_reset(0); enable = 1;
    feed(32'h0000_1000, 20);
    tests++; if ({full, frozen} !== 2'b11) begin fails++; $display("FAIL freeze_flags got %b want 11", {full, frozen}); end
    tests++; if (ovf_cnt !== 16'd4) begin fails++; $display("FAIL freeze_ovf got %0d want 4", ovf_cnt); end
    tests++; if (rd_seq !== 16'd0 || count !== 5'd16) begin fails++; $display("FAIL freeze_head got seq=%0d cnt=%0d want 0/16", rd_seq, count); end
    pop_one();
    tests++; if (frozen !== 1'b0 || count !== 5'd15 || rd_seq !== 16'd1) begin fails++; $display("FAIL freeze_pop got fz=%0b cnt=%0d seq=%0d want 0/15/1", frozen, count, rd_seq); end
  endtask

  task automatic test_wrap();
    do_reset(0); enable = 1; mode_wrap = 1;
    feed(32'h0000_1000, 20);
    tests++; if (count !== 5'd16 || frozen !== 1'b0) begin fails++; $display("FAIL wrap_count got cnt=%0d fz=%0b want 16/0", count, frozen); end
    tests++; if (ovf_cnt !== 16'd4) begin fails++; $display("FAIL wrap_ovf got %0d want 4", ovf_cnt); end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (rd_seq !== 16'(4 + k) || rd_pc !== 32'h1000 + 32'(4 * (4 + k))) begin
        fails++; $display("FAIL wrap_drain%0d got seq=%0d pc=%h want seq=%0d", k, rd_seq, rd_pc, 4 + k);
      end
      pop_one();
    end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL wrap_empty got %0b want 0", rd_valid); end
  endtask

  task automatic test_filter();
    do_reset(0); enable = 1;
    pc_lo = 32'h0040_0010; pc_hi = 32'h0040_0020;
    feed(32'h0040_0000, 13);
    tests++; if (count !== 5'd5) begin fails++; $display("FAIL filter_count got %0d want 5", count); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rd_seq !== 16'(i) || rd_pc !== 32'h0040_0010 + 32'(4 * i)) begin
        fails++; $display("FAIL filter_entry%0d got seq=%0d pc=%h want seq=%0d pc=%h", i, rd_seq, rd_pc, i, 32'h0040_0010 + 32'(4 * i));
      end
      pop_one();
    end
  endtask

  task automatic test_back_to_back();
    do_reset(0); enable = 1; mode_wrap = 1;
    feed(32'h0000_5000, 16);
    tests++; if (count !== 5'd16 || ovf_cnt !== 16'd0 || rd_seq !== 16'd0) begin fails++; $display("FAIL b2b_pre got cnt=%0d ovf=%0d seq=%0d want 16/0/0", count, ovf_cnt, rd_seq); end
    rd_ready = 1; hold(32'h0000_5040, 1); rd_ready = 0;
    tests++; if (count !== 5'd16 || ovf_cnt !== 16'd0) begin fails++; $display("FAIL b2b_post got cnt=%0d ovf=%0d want 16/0", count, ovf_cnt); end
    tests++; if (rd_seq !== 16'd1) begin fails++; $display("FAIL b2b_head got seq=%0d want 1", rd_seq); end
    for (int i = 0; i < 15; i++) pop_one();
    tests++; if (rd_seq !== 16'd16 || rd_pc !== 32'h0000_5040 || count !== 5'd1) begin fails++; $display("FAIL b2b_last got seq=%0d pc=%h cnt=%0d want 16/5040/1", rd_seq, rd_pc, count); end
  endtask

  task automatic test_clear_reset();
    do_reset(0); enable = 1;
    feed(32'h0000_2100, 3);
    clear = 1; hold(32'h0000_3000, 1); clear = 0;
    tests++; if (count !== 5'd0 || rd_valid !== 1'b0 || ovf_cnt !== 16'd0 || frozen !== 1'b0) begin fails++; $display("FAIL clear_state got cnt=%0d v=%0b ovf=%0d fz=%0b want 0/0/0/0", count, rd_valid, ovf_cnt, frozen); end
    feed(32'h0000_2000, 1);
    tests++; if (rd_seq !== 16'd0 || count !== 5'd1) begin fails++; $display("FAIL clear_seq got seq=%0d cnt=%0d want 0/1", rd_seq, count); end
    feed(32'h0000_2004, 17);
    tests++; if (ovf_cnt !== 16'd2 || frozen !== 1'b1) begin fails++; $display("FAIL prereset got ovf=%0d fz=%0b want 2/1", ovf_cnt, frozen); end
    #2 reset_n = 0;
    #1;
    tests++; if (count !== 5'd0 || rd_valid !== 1'b0 || ovf_cnt !== 16'd0 || frozen !== 1'b0) begin fails++; $display("FAIL async_reset got cnt=%0d v=%0b ovf=%0d fz=%0b want 0/0/0/0", count, rd_valid, ovf_cnt, frozen); end
    @(negedge clk_in);
    enable = 0; reset_n = 1;
    hold(32'h0000_7000, 2);
    tests++; if (count !== 5'd0 || frozen !== 1'b0) begin fails++; $display("FAIL idle_after got cnt=%0d fz=%0b want 0/0", count, frozen); end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_freeze();
    test_wrap();
    test_filter();
    test_back_to_back();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
